// File: rtl/duty_ramp_pkg.sv
// Shared types and helpers for the duty ramp controller.
// Optional target clamping is enabled by defining DUTY_RAMP_CLAMP_EN.
package duty_ramp_pkg;

    localparam int DUTY_W = 20;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    // Unsigned distance, one bit wider than the operands, so it can never wrap.
    function automatic logic [DUTY_W:0] abs_diff(
        input logic [DUTY_W-1:0] a,
        input logic [DUTY_W-1:0] b
    );
        if (a >= b) begin
            return {1'b0, a} - {1'b0, b};
        end else begin
            return {1'b0, b} - {1'b0, a};
        end
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] val,
        input logic [DUTY_W-1:0] lo,
        input logic [DUTY_W-1:0] hi
    );
        if (val < lo) begin
            return lo;
        end else if (val > hi) begin
            return hi;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/window_tick_gen.sv
// Free-running window counter; o_tick pulses on the last cycle of each window.
module window_tick_gen
    import duty_ramp_pkg::*;
#(
    parameter int SYS_FREQ   = 100000000,
    parameter int PULSE_FREQ = 50
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int WINDOW = SYS_FREQ / PULSE_FREQ;
    localparam int CNT_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    if (WINDOW < 2) begin : g_window_check
        $error("window_tick_gen: SYS_FREQ/PULSE_FREQ must be at least 2");
    end

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;
    logic             r_tick;

    // Next counter value with wrap at the end of the window.
    always_comb begin
        w_next = r_count + CNT_W'(1);
        if (r_count == LAST) begin
            w_next = '0;
        end else begin
            w_next = r_count + CNT_W'(1);
        end
    end

    // Tick is registered against the next count so it lines up with count == LAST.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_tick  <= (w_next == LAST);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/duty_ramp_controller.sv
// Slew-limited duty controller: moves duty_cycle toward an accepted target by at most
// STEP per PWM window. Define DUTY_RAMP_CLAMP_EN to clamp targets to [MIN_DUTY, MAX_DUTY].
module duty_ramp_controller
    import duty_ramp_pkg::*;
#(
    parameter int SYS_FREQ   = 100000000,
    parameter int PULSE_FREQ = 50,
    parameter int STEP       = 1000,
    parameter int RESET_DUTY = 150000,
    parameter int MIN_DUTY   = 100000,
    parameter int MAX_DUTY   = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              frame_tick,
    output logic              busy
);

`ifdef DUTY_RAMP_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [DUTY_W-1:0] RESET_V  = DUTY_W'(RESET_DUTY);
    localparam logic [DUTY_W-1:0] MIN_V    = DUTY_W'(MIN_DUTY);
    localparam logic [DUTY_W-1:0] MAX_V    = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W:0]   STEP_CMP = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);

    if (STEP == 0) begin : g_step_check
        $error("duty_ramp_controller: STEP must be non-zero");
    end

    if (CLAMP_EN && ((RESET_DUTY < MIN_DUTY) || (RESET_DUTY > MAX_DUTY))) begin : g_reset_range_check
        $error("duty_ramp_controller: RESET_DUTY outside [MIN_DUTY, MAX_DUTY]");
    end

    ramp_state_t       r_state;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_duty;
    logic              r_busy;
    logic              r_ready;
    logic              w_tick;
    logic [DUTY_W-1:0] w_tgt;
    logic [DUTY_W:0]   w_diff;

    window_tick_gen #(
        .SYS_FREQ   (SYS_FREQ),
        .PULSE_FREQ (PULSE_FREQ)
    ) u_window_tick_gen (
        .i_clk   (clk),
        .i_reset (reset),
        .o_tick  (w_tick)
    );

    assign w_tgt  = CLAMP_EN ? clamp_duty(tgt_duty, MIN_V, MAX_V) : tgt_duty;
    assign w_diff = abs_diff(r_target, r_duty);

    // Ramp FSM: accept in IDLE, step duty only on window boundaries in RAMP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_target <= RESET_V;
            r_duty   <= RESET_V;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tgt_valid && r_ready) begin
                        r_target <= w_tgt;
                        if (w_tgt != r_duty) begin
                            r_state <= RAMP;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                RAMP: begin
                    if (w_tick) begin
                        if (w_diff <= STEP_CMP) begin
                            r_duty  <= r_target;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end else if (r_target > r_duty) begin
                            r_duty <= r_duty + STEP_V;
                        end else begin
                            r_duty <= r_duty - STEP_V;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign duty_cycle = r_duty;
    assign busy       = r_busy;
    assign tgt_ready  = r_ready;
    assign frame_tick = w_tick;

endmodule

// File: tb/tb_duty_ramp_controller.sv
// Directed bench for duty_ramp_controller with WINDOW = 100, STEP = 1000.
// Define DUTY_RAMP_CLAMP_EN for both RTL and bench to exercise the clamped build.
module tb_duty_ramp_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [19:0] tgt_duty;
    logic [19:0] duty_cycle;
    logic        frame_tick;
    logic        busy;

    int total  = 0;
    int passes = 0;
    int n;

    duty_ramp_controller #(
        .SYS_FREQ   (1000),
        .PULSE_FREQ (10),
        .STEP       (1000),
        .RESET_DUTY (150000),
        .MIN_DUTY   (100000),
        .MAX_DUTY   (200000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_duty   (tgt_duty),
        .duty_cycle (duty_cycle),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance on falling edges until frame_tick is seen, bounded to 300 cycles.
    task automatic wait_tick(input string tag, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_tick && cnt < 300);
        chk({tag, "_tick_seen"}, {31'd0, frame_tick}, 32'd1);
    endtask

    task automatic step_check(input string tag, input logic [31:0] exp_duty);
        int c;
        wait_tick(tag, c);
        @(negedge clk);
        chk(tag, {12'd0, duty_cycle}, exp_duty);
    endtask

    task automatic offer(input logic [19:0] d);
        tgt_valid = 1'b1;
        tgt_duty  = d;
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        tgt_valid = 1'b0;
        tgt_duty  = 20'd0;
        repeat (3) @(negedge clk);
        chk("rst_duty",  {12'd0, duty_cycle}, 32'd150000);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_ready", {31'd0, tgt_ready},  32'd1);
        chk("rst_tick",  {31'd0, frame_tick}, 32'd0);

        reset = 1'b0;
        wait_tick("p1", n);
        chk("first_period", n, 32'd99);
        wait_tick("p2", n);
        chk("period", n, 32'd100);
        chk("idle_duty", {12'd0, duty_cycle}, 32'd150000);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Acceptance lands on a frame_tick edge: duty must not move yet.
        offer(20'd153500);
        chk("acc_on_tick_duty", {12'd0, duty_cycle}, 32'd150000);
        chk("acc_busy",  {31'd0, busy},      32'd1);
        chk("acc_ready", {31'd0, tgt_ready}, 32'd0);
        step_check("up1", 32'd151000);
        step_check("up2", 32'd152000);
        step_check("up3", 32'd153000);
        chk("up3_busy", {31'd0, busy}, 32'd1);
        step_check("up4", 32'd153500);
        chk("up_done_busy",  {31'd0, busy},      32'd0);
        chk("up_done_ready", {31'd0, tgt_ready}, 32'd1);

        // Target held valid during a ramp is only taken once IDLE returns.
        tgt_valid = 1'b1;
        tgt_duty  = 20'd152000;
        @(negedge clk);
        chk("dn_busy", {31'd0, busy}, 32'd1);
        tgt_duty = 20'd151000;
        @(negedge clk);
        chk("ramp_ready", {31'd0, tgt_ready}, 32'd0);
        step_check("dn1", 32'd152500);
        chk("dn1_busy", {31'd0, busy}, 32'd1);
        step_check("dn2", 32'd152000);
        chk("dn2_busy",  {31'd0, busy},      32'd0);
        chk("dn2_ready", {31'd0, tgt_ready}, 32'd1);
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("reaccept_busy", {31'd0, busy}, 32'd1);
        step_check("exact_step", 32'd151000);
        chk("exact_step_busy", {31'd0, busy}, 32'd0);

        // Target equal to current duty stays in IDLE.
        offer(20'd151000);
        chk("equal_busy",  {31'd0, busy},      32'd0);
        chk("equal_ready", {31'd0, tgt_ready}, 32'd1);

        // Asynchronous reset mid-ramp.
        offer(20'd153500);
        step_check("pre_rst", 32'd152000);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_duty",  {12'd0, duty_cycle}, 32'd150000);
        chk("async_rst_busy",  {31'd0, busy},       32'd0);
        chk("async_rst_ready", {31'd0, tgt_ready},  32'd1);
        chk("async_rst_tick",  {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_tick("post_rst", n);
        chk("post_rst_period", n, 32'd99);
        @(negedge clk);
        chk("post_rst_duty", {12'd0, duty_cycle}, 32'd150000);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Downward ramp with a short final step.
        offer(20'd148200);
        step_check("under1", 32'd149000);
        step_check("under2", 32'd148200);
        chk("under_busy", {31'd0, busy}, 32'd0);

        // Out-of-range target: clamped to 200000 only in the clamped build.
        offer(20'd900000);
        step_check("big1", 32'd149200);
        step_check("big2", 32'd150200);
        chk("big_ready", {31'd0, tgt_ready}, 32'd0);
        for (int i = 0; i < 48; i++) begin
            wait_tick("big_run", n);
        end
        @(negedge clk);
        chk("big_mid", {12'd0, duty_cycle}, 32'd198200);
        step_check("big3", 32'd199200);
`ifdef DUTY_RAMP_CLAMP_EN
        step_check("big_end", 32'd200000);
        chk("big_end_busy", {31'd0, busy}, 32'd0);
`else
        step_check("big_end", 32'd200200);
        chk("big_end_busy", {31'd0, busy}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
